gray_rx: RTL and testbench
==========================

GRAY_RX -- requirements
Module: gray_rx

Interface
REQ-001 Parameter W, default 10, width of Gray code bus.
REQ-002 Parameter STABLE, default 4, consecutive identical synchronized samples required to accept a code (legal range 1..15).
REQ-003 CLK  input  1  single clock, rising-edge; all state in this domain.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 GRAY_IN  input  W  external Gray-coded count, asynchronous to CLK.
REQ-006 CLR_ERR  input  1  synchronous clear of STEP_ERR and ERR_CNT.
REQ-007 BIN_OUT  output  W  binary value of last accepted code.
REQ-008 VALID  output  1  one-cycle pulse on each accepted legal step.
REQ-009 DIR  output  1  direction of last legal step: 1 = +1, 0 = -1.
REQ-010 JUMP  output  1  one-cycle pulse on each accepted illegal step.
REQ-011 STEP_ERR  output  1  sticky illegal-step flag.
REQ-012 ERR_CNT  output  8  saturating illegal-step count.
REQ-013 LOCKED  output  1  high once a first code has been accepted.

Function
REQ-014 GRAY_IN SHALL pass through a two-flop synchronizer before any other use.
REQ-015 A stability counter SHALL reset to 0 when the synchronized sample differs from the previous one and increment (saturating at STABLE) otherwise; candidate accepted on the cycle it reaches STABLE-1 → STABLE only, never re-accepted while unchanged.
REQ-016 Accepted candidate SHALL be converted Gray→binary: b[W-1]=g[W-1], b[i]=b[i+1]^g[i].
REQ-017 FSM states: UNLOCKED, TRACK; reset → UNLOCKED.
REQ-018 UNLOCKED: first accepted code loads BIN_OUT, sets LOCKED, → TRACK; no VALID, no JUMP, no error.
REQ-019 TRACK, new binary == BIN_OUT+1 mod 2^W: load BIN_OUT, DIR=1, VALID pulse.
REQ-020 TRACK, new binary == BIN_OUT-1 mod 2^W: load BIN_OUT, DIR=0, VALID pulse.
REQ-021 TRACK, new binary equals BIN_OUT: no output change.
REQ-022 TRACK, any other value: load BIN_OUT (resync), DIR unchanged, JUMP pulse, STEP_ERR=1, ERR_CNT+1 saturating at 255.
REQ-023 Wrap-around legal: 2^W-1→0 is +1, 0→2^W-1 is -1.
REQ-024 VALID and JUMP SHALL never assert in the same cycle.
REQ-025 Latency: GRAY_IN stable before edge n → VALID/JUMP and BIN_OUT update registered at edge n+STABLE+2.
REQ-026 CLR_ERR alone: STEP_ERR=0, ERR_CNT=0 next edge; CLR_ERR coincident with illegal step: STEP_ERR=1, ERR_CNT=1.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 RST_N low SHALL immediately force: BIN_OUT=0, VALID=0, DIR=0, JUMP=0, STEP_ERR=0, ERR_CNT=0, LOCKED=0, synchronizer flops=0, stability counter=0, FSM=UNLOCKED.
REQ-029 Reset mid-filter SHALL discard the pending candidate; after release the first accepted code is treated per REQ-018.

Structure
REQ-030 Shared package gray_pkg SHALL hold default W, default STABLE, FSM state encoding, and the gray2bin function.
REQ-031 Sub-module gray_filter SHALL contain synchronizer plus stability counter, outputting candidate code and one-cycle accept strobe.
REQ-032 Top gray_rx SHALL contain FSM, step classification, error logic.

Verification
REQ-033 Reset release, GRAY_IN=10'h000 held → LOCKED=1 and BIN_OUT=0 at edge 6 after release, VALID and JUMP never pulse.
REQ-034 Locked at 0, drive Gray 1,3,2 (binary 1,2,3) each held 10 cycles → three VALID pulses, DIR=1, BIN_OUT 1,2,3, each update exactly STABLE+2 edges after change.
REQ-035 Locked at binary 0, drive Gray 10'h200 (binary 1023) → VALID, DIR=0, BIN_OUT=1023; then Gray 0 → VALID, DIR=1, BIN_OUT=0.
REQ-036 Locked at 0, drive Gray 10'h008 (binary 15) → JUMP pulse, STEP_ERR=1, ERR_CNT=1, BIN_OUT=15, no VALID; 300 further illegal jumps → ERR_CNT=255.
REQ-037 Glitch: GRAY_IN toggles to new value for STABLE-1 synchronized cycles then returns → no VALID, no JUMP, BIN_OUT unchanged.
REQ-038 CLR_ERR asserted same cycle as illegal-step accept → STEP_ERR=1, ERR_CNT=1; RST_N pulsed mid-filter → all outputs 0 immediately, LOCKED=0.

Source files
------------

// File: rtl/gray_pkg.sv
`timescale 1ns/1ps
// Shared defaults, FSM encoding and Gray->binary decode for the Gray-count receiver.
package gray_pkg;

  localparam int GRAY_W_DEF = 10;
  localparam int STABLE_DEF = 4;
  localparam int STAB_CNT_W = 4;
  localparam int GRAY_MAX_W = 32;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_TRACK    = 1'b1
  } rx_state_e;

  // Callers zero-extend narrower codes; leading zeros leave the low bits unchanged.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_filter.sv
`timescale 1ns/1ps
// Two-flop synchronizer plus stability filter; accept strobe fires once per stable code,
// combinationally on the cycle the run count goes STABLE-1 -> STABLE.
module gray_filter
  import gray_pkg::*;
#(
  parameter int W      = GRAY_W_DEF,
  parameter int STABLE = STABLE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] gray_in,
  output logic [W-1:0] cand_dat,
  output logic         acc_vld
);

  localparam logic [STAB_CNT_W-1:0] CNT_MAX = STAB_CNT_W'(STABLE);
  localparam logic [STAB_CNT_W-1:0] CNT_ACC = STAB_CNT_W'(STABLE - 1);

  logic [W-1:0]          sync1_q, sync1_d;
  logic [W-1:0]          sync2_q, sync2_d;
  logic [W-1:0]          prev_q, prev_d;
  logic [1:0]            fill_q, fill_d;
  logic [STAB_CNT_W-1:0] cnt_q, cnt_d;
  logic                  same;

  // fill_q marks when the synchronizer holds real samples rather than reset zeros.
  always_comb begin
    sync1_d = gray_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fill_d  = {fill_q[0], 1'b1};
    same    = fill_q[1] && (sync2_q == prev_q);
    cnt_d   = '0;
    if (same) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + STAB_CNT_W'(1);
    end
    acc_vld = same && (cnt_q == CNT_ACC);
  end

  assign cand_dat = prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/gray_rx.sv
`timescale 1ns/1ps
// Gray-count receiver: filters, decodes and classifies each accepted code as +1/-1/jump.
// Outputs registered, updating STABLE+2 edges after the input settles.
module gray_rx
  import gray_pkg::*;
#(
  parameter int W      = GRAY_W_DEF,
  parameter int STABLE = STABLE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] gray_in,
  input  logic         clr_err,
  output logic [W-1:0] bin_out,
  output logic         valid,
  output logic         dir,
  output logic         jump,
  output logic         step_err,
  output logic [7:0]   err_cnt,
  output logic         locked
);

  logic [W-1:0] cand_dat;
  logic         acc_vld;
  logic [W-1:0] cand_bin, bin_inc, bin_dec;

  rx_state_e    state_q, state_d;
  logic [W-1:0] bin_q, bin_d;
  logic         valid_q, valid_d, dir_q, dir_d, jump_q, jump_d;
  logic         step_err_q, step_err_d, locked_q, locked_d;
  logic [7:0]   err_cnt_q, err_cnt_d;

  gray_filter #(.W(W), .STABLE(STABLE)) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .gray_in  (gray_in),
    .cand_dat (cand_dat),
    .acc_vld  (acc_vld)
  );

  assign cand_bin = W'(gray2bin(GRAY_MAX_W'(cand_dat)));
  assign bin_inc  = bin_q + W'(1);
  assign bin_dec  = bin_q - W'(1);

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    dir_d      = dir_q;
    locked_d   = locked_q;
    valid_d    = 1'b0;
    jump_d     = 1'b0;
    step_err_d = clr_err ? 1'b0 : step_err_q;
    err_cnt_d  = clr_err ? 8'd0 : err_cnt_q;
    if (acc_vld) begin
      case (state_q)
        ST_UNLOCKED: begin
          bin_d    = cand_bin;
          locked_d = 1'b1;
          state_d  = ST_TRACK;
        end
        default: begin
          if (cand_bin == bin_inc) begin
            bin_d   = cand_bin;
            dir_d   = 1'b1;
            valid_d = 1'b1;
          end else if (cand_bin == bin_dec) begin
            bin_d   = cand_bin;
            dir_d   = 1'b0;
            valid_d = 1'b1;
          end else if (cand_bin != bin_q) begin
            // Resync to the new value; an error coincident with a clear still counts.
            bin_d      = cand_bin;
            jump_d     = 1'b1;
            step_err_d = 1'b1;
            if (clr_err) begin
              err_cnt_d = 8'd1;
            end else if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_UNLOCKED;
      bin_q      <= '0;
      valid_q    <= 1'b0;
      dir_q      <= 1'b0;
      jump_q     <= 1'b0;
      step_err_q <= 1'b0;
      err_cnt_q  <= 8'd0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      valid_q    <= valid_d;
      dir_q      <= dir_d;
      jump_q     <= jump_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign bin_out  = bin_q;
  assign valid    = valid_q;
  assign dir      = dir_q;
  assign jump     = jump_q;
  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_gray_rx.sv
`timescale 1ns/1ps
// Directed bench for gray_rx: lock, legal steps, wrap, jumps, glitch, error clear, reset.
module tb_gray_rx;

  localparam int W  = 10;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr_err = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic [W-1:0] bin_out;
  logic         valid, dir, jump, step_err, locked;
  logic [7:0]   err_cnt;

  int checks = 0;
  int failures = 0;
  int vld_seen = 0;
  int jmp_seen = 0;
  int both_seen = 0;
  logic [W-1:0] cur_bin = '0;

  gray_rx #(.W(W), .STABLE(ST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gray_in  (gray_in),
    .clr_err  (clr_err),
    .bin_out  (bin_out),
    .valid    (valid),
    .dir      (dir),
    .jump     (jump),
    .step_err (step_err),
    .err_cnt  (err_cnt),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) vld_seen++;
      if (jump) jmp_seen++;
      if (valid && jump) both_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Change the input right after an edge; the result must appear exactly STABLE+3 edges later.
  task automatic do_step(input string tag, input logic [W-1:0] g, input logic [W-1:0] exp_bin,
                         input bit exp_v, input bit exp_j, input bit exp_dir, input bit clr_at_acc);
    int v0;
    int j0;
    v0 = vld_seen;
    j0 = jmp_seen;
    gray_in = g;
    tick(ST + 2);
    check({tag, "_early"}, 32'(bin_out), 32'(cur_bin));
    if (clr_at_acc) clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check({tag, "_bin"}, 32'(bin_out), 32'(exp_bin));
    check({tag, "_valid"}, 32'(valid), 32'(exp_v));
    check({tag, "_jump"}, 32'(jump), 32'(exp_j));
    check({tag, "_dir"}, 32'(dir), 32'(exp_dir));
    tick(4);
    check({tag, "_nvld"}, 32'(vld_seen - v0), 32'(exp_v));
    check({tag, "_njmp"}, 32'(jmp_seen - j0), 32'(exp_j));
    cur_bin = exp_bin;
  endtask

  initial begin
    int v0;
    int j0;

    tick(3);
    check("rst_bin", 32'(bin_out), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_jump", 32'(jump), 32'd0);
    check("rst_dir", 32'(dir), 32'd0);
    check("rst_err", 32'(step_err), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);

    rst_n = 1'b1;
    tick(5);
    check("lock_edge5", 32'(locked), 32'd0);
    tick(1);
    check("lock_edge6", 32'(locked), 32'd1);
    check("lock_bin", 32'(bin_out), 32'd0);
    tick(10);
    check("lock_nvld", 32'(vld_seen), 32'd0);
    check("lock_njmp", 32'(jmp_seen), 32'd0);

    do_step("up1", 10'h001, 10'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    do_step("up2", 10'h003, 10'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    do_step("up3", 10'h002, 10'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    do_step("dn2", 10'h003, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    do_step("dn1", 10'h001, 10'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_step("dn0", 10'h000, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_step("wrap_dn", 10'h200, 10'd1023, 1'b1, 1'b0, 1'b0, 1'b0);
    do_step("wrap_up", 10'h000, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Glitch lasting STABLE-1 synchronized samples must be ignored.
    v0 = vld_seen;
    j0 = jmp_seen;
    gray_in = 10'h001;
    tick(ST - 1);
    gray_in = 10'h000;
    tick(14);
    check("glitch_bin", 32'(bin_out), 32'd0);
    check("glitch_nvld", 32'(vld_seen - v0), 32'd0);
    check("glitch_njmp", 32'(jmp_seen - j0), 32'd0);

    do_step("jump15", 10'h008, 10'd15, 1'b0, 1'b1, 1'b1, 1'b0);
    check("jump15_err", 32'(step_err), 32'd1);
    check("jump15_cnt", 32'(err_cnt), 32'd1);

    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr_err", 32'(step_err), 32'd0);
    check("clr_cnt", 32'(err_cnt), 32'd0);

    // binary 100, Gray 10'h056, with clear landing on the accept edge
    do_step("jump_clr", 10'h056, 10'd100, 1'b0, 1'b1, 1'b1, 1'b1);
    check("jump_clr_err", 32'(step_err), 32'd1);
    check("jump_clr_cnt", 32'(err_cnt), 32'd1);

    // Alternate binary 500 (Gray 10'h10E) and binary 100 for 300 illegal jumps.
    v0 = vld_seen;
    j0 = jmp_seen;
    for (int i = 0; i < 300; i++) begin
      gray_in = (i % 2 == 0) ? 10'h10E : 10'h056;
      tick(ST + 4);
    end
    check("sat_cnt", 32'(err_cnt), 32'd255);
    check("sat_njmp", 32'(jmp_seen - j0), 32'd300);
    check("sat_nvld", 32'(vld_seen - v0), 32'd0);
    check("sat_bin", 32'(bin_out), 32'd100);

    // Reset while a new code is still in the filter.
    gray_in = 10'h008;
    tick(3);
    rst_n = 1'b0;
    #2;
    check("mid_rst_bin", 32'(bin_out), 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_dir", 32'(dir), 32'd0);
    check("mid_rst_err", 32'(step_err), 32'd0);
    check("mid_rst_cnt", 32'(err_cnt), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_jump", 32'(jump), 32'd0);
    tick(2);
    v0 = vld_seen;
    j0 = jmp_seen;
    rst_n = 1'b1;
    tick(12);
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_bin", 32'(bin_out), 32'd15);
    check("relock_err", 32'(step_err), 32'd0);
    check("relock_nvld", 32'(vld_seen - v0), 32'd0);
    check("relock_njmp", 32'(jmp_seen - j0), 32'd0);

    check("vld_jump_overlap", 32'(both_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
